// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state
//   id_w()      : requester index width for a given requester count
//   bcnt_w()    : burst beat counter width for a given burst length
//   ZERO_DATA   : all-zero beat, sliced to DATA_WIDTH by users (DATA_WIDTH <= MAX_DATA_W)
package fifo_arb_pkg;

   localparam int unsigned MAX_DATA_W = 64;
   localparam logic [MAX_DATA_W-1:0] ZERO_DATA = '0;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index width; a single-bit minimum keeps every vector legal.
   function automatic int unsigned id_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Counter width able to hold 0..b.
   function automatic int unsigned bcnt_w(input int unsigned b);
      return (b > 0) ? $clog2(b + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: returns the first set bit of req scanning upward
// from ptr and wrapping NUM_REQ-1 -> 0. Purely combinational.
//   req : request vector
//   ptr : scan start index (0..NUM_REQ-1)
//   any : at least one request set
//   idx : winning index, 0 when any=0
module rr_priority_picker
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [ID_W-1:0]    idx
);

   // Rotate-and-encode: the first hit in scan order wins.
   always_comb begin
      int unsigned cand;
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(ptr) + k) % NUM_REQ;
         if (!any && req[ID_W'(cand)]) begin
            any = 1'b1;
            idx = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port among NUM_REQ
// valid/ready producers. Build option: define BURST_LOCK_EN to let an owner keep
// the port for up to BURST_LEN consecutive beats; otherwise one beat per grant.
//   clk, rst_n    : clock, synchronous active-low reset
//   req_valid     : per-requester beat valid
//   req_data      : beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     : per-requester accept, one-hot or zero
//   fifo_full     : FIFO full flag
//   fifo_wr_en    : FIFO write enable
//   fifo_data_in  : FIFO write data
//   grant_vld     : a requester owns the port
//   grant_id      : owner index, 0 when grant_vld=0
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned DATA_WIDTH = 6,
   parameter  int unsigned BURST_LEN  = 4,
   localparam int unsigned ID_W       = id_w(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          grant_vld,
   output logic [ID_W-1:0]               grant_id
);

   // Elaboration-time configuration guards.
   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("fifo_write_arbiter: NUM_REQ must be >= 2");
   end
   if (BURST_LEN < 1) begin : g_bad_burst_len
      $error("fifo_write_arbiter: BURST_LEN must be >= 1");
   end

   arb_state_e          state_q, state_d;
   logic [ID_W-1:0]     owner_q, owner_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]  owner_mask, pick_req;
   logic [ID_W-1:0]     pick_idx, pick_next;
   logic                pick_any;
   logic                granted, owner_valid, beat, do_release, new_grant;

   // Reset gates the grant at once so nothing is written in a reset cycle.
   assign granted     = rst_n && (state_q == GRANT);
   assign owner_mask  = NUM_REQ'(1) << owner_q;
   assign owner_valid = |(req_valid & owner_mask);
   assign beat        = granted && !fifo_full && owner_valid;

   // Combinational handshake path.
   assign req_ready    = (granted && !fifo_full) ? owner_mask : '0;
   assign fifo_wr_en   = beat;
   assign fifo_data_in = granted ? req_data[32'(owner_q)*DATA_WIDTH +: DATA_WIDTH]
                                 : ZERO_DATA[DATA_WIDTH-1:0];
   assign grant_vld    = granted;
   assign grant_id     = granted ? owner_q : '0;

   // A releasing owner is masked so the next owner follows with no bubble.
   assign pick_req  = (state_q == GRANT) ? (req_valid & ~owner_mask) : req_valid;
   assign pick_next = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req (pick_req),
      .ptr (rr_ptr_q),
      .any (pick_any),
      .idx (pick_idx)
   );

`ifdef BURST_LOCK_EN
   localparam int unsigned BCNT_W = bcnt_w(BURST_LEN);
   logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic              burst_last;

   assign burst_last = (beat_cnt_q == BCNT_W'(BURST_LEN - 1));
   assign do_release = !owner_valid || (beat && burst_last);
`else
   assign do_release = !owner_valid || beat;
`endif

   assign new_grant = pick_any && ((state_q == IDLE) || do_release);

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
`ifdef BURST_LOCK_EN
      beat_cnt_d = beat_cnt_q;
`endif
      case (state_q)
         IDLE, GRANT: begin
            if (new_grant) begin
               state_d  = GRANT;
               owner_d  = pick_idx;
               rr_ptr_d = pick_next;
`ifdef BURST_LOCK_EN
               beat_cnt_d = '0;
`endif
            end else if ((state_q == GRANT) && do_release) begin
               state_d = IDLE;
               owner_d = '0;
            end
`ifdef BURST_LOCK_EN
            else if (beat) begin
               beat_cnt_d = beat_cnt_q + BCNT_W'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
`ifdef BURST_LOCK_EN
         beat_cnt_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
`ifdef BURST_LOCK_EN
         beat_cnt_q <= beat_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: a depth-8 FIFO model on the write port, per-requester
// producer queues and a per-requester scoreboard checked on every FIFO write.
module tb_fifo_write_arbiter;

   localparam int unsigned NUM_REQ    = 4;
   localparam int unsigned DATA_WIDTH = 6;
   localparam int unsigned BURST_LEN  = 4;
   localparam int unsigned ID_W       = 2;
   localparam int          DEPTH      = 8;

   logic                          clk;
   logic                          rst_n;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          fifo_full;
   logic                          fifo_wr_en;
   logic [DATA_WIDTH-1:0]         fifo_data_in;
   logic                          grant_vld;
   logic [ID_W-1:0]               grant_id;

   int errors = 0;
   int checks = 0;

   logic [DATA_WIDTH-1:0] src   [NUM_REQ][$];
   logic [DATA_WIDTH-1:0] exp_q [NUM_REQ][$];
   logic [DATA_WIDTH-1:0] fifo_q[$];
   int                    fifo_cnt = 0;
   logic                  rd_req;

   fifo_write_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .BURST_LEN  (BURST_LEN)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_data_in (fifo_data_in),
      .grant_vld    (grant_vld),
      .grant_id     (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_full = (fifo_cnt >= DEPTH);

   // FIFO model plus scoreboard on every write.
   always @(posedge clk) begin
      logic [DATA_WIDTH-1:0] exp_d;
      if (!rst_n) begin
         fifo_q.delete();
         fifo_cnt <= 0;
      end else begin
         if (rd_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
         if (fifo_wr_en) begin
            checks++;
            if (fifo_full) begin
               errors++;
               $display("FAIL write_when_full id=%0d data=%0h got wr_en=1 exp wr_en=0", grant_id, fifo_data_in);
            end else begin
               fifo_q.push_back(fifo_data_in);
               if (exp_q[grant_id].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write id=%0d got data=%0h exp no write", grant_id, fifo_data_in);
               end else begin
                  exp_d = exp_q[grant_id].pop_front();
                  if (fifo_data_in !== exp_d) begin
                     errors++;
                     $display("FAIL write_data id=%0d got=%0h exp=%0h", grant_id, fifo_data_in, exp_d);
                  end
               end
            end
         end
         fifo_cnt <= fifo_q.size();
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (src[i].size() > 0);
         req_data[i*DATA_WIDTH +: DATA_WIDTH] = (src[i].size() > 0) ? src[i][0] : '0;
      end
   endtask

   // One clock: capture handshakes, advance producers, settle, return at posedge+2.
   task automatic tick();
      logic [NUM_REQ-1:0] hs;
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      for (int i = 0; i < NUM_REQ; i++)
         if (hs[i] && src[i].size() > 0) void'(src[i].pop_front());
      #1 drive();
      #1;
   endtask

   task automatic push(input int i, input logic [DATA_WIDTH-1:0] d);
      src[i].push_back(d);
      exp_q[i].push_back(d);
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < NUM_REQ; i++)
         if (src[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit exp_empty();
      for (int i = 0; i < NUM_REQ; i++)
         if (exp_q[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!(all_empty() && !grant_vld) && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s_timeout got=%0d cycles exp<%0d", name, n, budget);
      end
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      rd_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         src[i].delete();
         exp_q[i].delete();
      end
      drive();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      rd_req = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) src[i].push_back(6'(i + 1));
      drive();
      tick();
      tick();
      checks += 4;
      if (grant_vld !== 1'b0) begin errors++; $display("FAIL reset_grant_vld got=%b exp=0", grant_vld); end
      if (grant_id !== '0) begin errors++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
      if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
      if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
      do_reset();
   endtask

   task automatic test_single();
      logic [DATA_WIDTH-1:0] exp_rd [3];
      exp_rd = '{6'h11, 6'h12, 6'h13};
      do_reset();
      push(0, 6'h11);
      push(0, 6'h12);
      push(0, 6'h13);
      drive();
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_no_ready_same_cycle got=%b exp=0000", req_ready); end
      tick();
      checks += 2;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_first_ready got=%b exp=0001", req_ready); end
      if (fifo_data_in !== 6'h11) begin errors++; $display("FAIL single_first_data got=%0h exp=11", fifo_data_in); end
      wait_done("single", 30);
      checks++;
      if (fifo_q.size() != 3) begin
         errors++;
         $display("FAIL single_fifo_count got=%0d exp=3", fifo_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (fifo_q[k] !== exp_rd[k]) begin
               errors++;
               $display("FAIL single_fifo_order k=%0d got=%0h exp=%0h", k, fifo_q[k], exp_rd[k]);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      rd_req = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
         for (int j = 0; j < 3; j++) push(i, 6'(i*8 + j));
      drive();
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (!(grant_vld === 1'b1 && grant_id === ID_W'(k % 4) && fifo_wr_en === 1'b1)) begin
            errors++;
            $display("FAIL rr_sequence k=%0d got vld=%b id=%0d wr=%b exp vld=1 id=%0d wr=1",
                     k, grant_vld, grant_id, fifo_wr_en, k % 4);
         end
      end
      wait_done("rr", 40);
      checks++;
      if (!exp_empty()) begin errors++; $display("FAIL rr_scoreboard_left got=nonempty exp=empty"); end
      rd_req = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      for (int j = 0; j < 8; j++) push(0, 6'(8'h20 + j));
      drive();
      wait_done("full_fill", 40);
      checks++;
      if (fifo_full !== 1'b1) begin errors++; $display("FAIL full_after_fill got=%b exp=1", fifo_full); end
      push(2, 6'h2A);
      drive();
      tick();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (!(grant_vld === 1'b1 && grant_id === 2'd2 && req_ready === 4'b0000 && fifo_wr_en === 1'b0)) begin
            errors++;
            $display("FAIL full_hold k=%0d got vld=%b id=%0d ready=%b wr=%b exp vld=1 id=2 ready=0000 wr=0",
                     k, grant_vld, grant_id, req_ready, fifo_wr_en);
         end
         tick();
      end
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      checks++;
      if (!(req_ready === 4'b0100 && fifo_wr_en === 1'b1 && fifo_data_in === 6'h2A)) begin
         errors++;
         $display("FAIL full_pop_accept got ready=%b wr=%b data=%0h exp ready=0100 wr=1 data=2a",
                  req_ready, fifo_wr_en, fifo_data_in);
      end
      tick();
      checks++;
      if (!(fifo_full === 1'b1 && grant_vld === 1'b0)) begin
         errors++;
         $display("FAIL full_reassert got full=%b vld=%b exp full=1 vld=0", fifo_full, grant_vld);
      end
      rd_req = 1'b1;
      repeat (10) tick();
      rd_req = 1'b0;
   endtask

   task automatic test_drop();
      do_reset();
      rd_req = 1'b1;
      src[1].push_back(6'h31);
      push(3, 6'h33);
      drive();
      tick();
      checks++;
      if (grant_id !== 2'd1 || grant_vld !== 1'b1) begin
         errors++;
         $display("FAIL drop_first_owner got vld=%b id=%0d exp vld=1 id=1", grant_vld, grant_id);
      end
      src[1].delete();
      drive();
      #1;
      checks++;
      if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL drop_no_write got=%b exp=0", fifo_wr_en); end
      tick();
      checks++;
      if (!(grant_vld === 1'b1 && grant_id === 2'd3 && fifo_wr_en === 1'b1 && fifo_data_in === 6'h33)) begin
         errors++;
         $display("FAIL drop_handover got vld=%b id=%0d wr=%b data=%0h exp vld=1 id=3 wr=1 data=33",
                  grant_vld, grant_id, fifo_wr_en, fifo_data_in);
      end
      wait_done("drop", 20);
      checks++;
      if (!exp_empty()) begin errors++; $display("FAIL drop_scoreboard_left got=nonempty exp=empty"); end
      rd_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      rd_req = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
         for (int j = 0; j < 2; j++) push(i, 6'(i*4 + j + 40));
      drive();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if (!(grant_vld === 1'b0 && fifo_wr_en === 1'b0 && req_ready === 4'b0000)) begin
         errors++;
         $display("FAIL reset_mid_drop got vld=%b wr=%b ready=%b exp vld=0 wr=0 ready=0000",
                  grant_vld, fifo_wr_en, req_ready);
      end
      tick();
      rst_n = 1'b1;
      tick();
      checks++;
      if (!(grant_vld === 1'b1 && grant_id === 2'd0 && fifo_data_in === 6'd41)) begin
         errors++;
         $display("FAIL reset_mid_restart got vld=%b id=%0d data=%0d exp vld=1 id=0 data=41",
                  grant_vld, grant_id, fifo_data_in);
      end
      wait_done("reset_mid", 40);
      checks++;
      if (!exp_empty()) begin errors++; $display("FAIL reset_mid_scoreboard_left got=nonempty exp=empty"); end
      rd_req = 1'b0;
   endtask

`ifdef BURST_LOCK_EN
   task automatic test_burst();
      int exp_id [7];
      bit exp_wr [7];
      exp_id = '{0, 0, 0, 1, 1, 1, 1};
      exp_wr = '{1, 1, 0, 1, 1, 1, 1};
      do_reset();
      rd_req = 1'b1;
      for (int j = 0; j < 6; j++) begin
         push(0, 6'(j));
         push(1, 6'(16 + j));
      end
      drive();
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (!(grant_vld === 1'b1 && grant_id === ID_W'(k < 4 ? 0 : 1) && fifo_wr_en === 1'b1)) begin
            errors++;
            $display("FAIL burst_sequence k=%0d got vld=%b id=%0d wr=%b exp vld=1 id=%0d wr=1",
                     k, grant_vld, grant_id, fifo_wr_en, (k < 4) ? 0 : 1);
         end
      end
      wait_done("burst", 40);
      do_reset();
      rd_req = 1'b1;
      for (int j = 0; j < 2; j++) push(0, 6'(32 + j));
      for (int j = 0; j < 4; j++) push(1, 6'(48 + j));
      drive();
      for (int k = 0; k < 7; k++) begin
         tick();
         checks++;
         if (!(grant_vld === 1'b1 && grant_id === ID_W'(exp_id[k]) && fifo_wr_en === exp_wr[k])) begin
            errors++;
            $display("FAIL burst_early_release k=%0d got vld=%b id=%0d wr=%b exp vld=1 id=%0d wr=%b",
                     k, grant_vld, grant_id, fifo_wr_en, exp_id[k], exp_wr[k]);
         end
      end
      wait_done("burst_early", 20);
      checks++;
      if (!exp_empty()) begin errors++; $display("FAIL burst_scoreboard_left got=nonempty exp=empty"); end
      rd_req = 1'b0;
   endtask
`endif

   initial begin
      rst_n     = 1'b0;
      rd_req    = 1'b0;
      req_valid = '0;
      req_data  = '0;
      test_reset();
      test_single();
`ifndef BURST_LOCK_EN
      test_round_robin();
`endif
      test_full();
      test_drop();
      test_reset_mid();
`ifdef BURST_LOCK_EN
      test_burst();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
